// File: rtl/cond_logic_unit.sv
// Conditional-execution unit: holds the NZCV flag register, evaluates the
// instruction's 4-bit condition field against it, gates the decoder's
// PC/regfile/memory write strobes, and counts executed vs squashed instructions.
//
// Transfer semantics: 'en' is the instruction-valid qualifier. There is no ready
// back-pressure; every cycle with en=1 is one instruction that is consumed and
// either executed (cond_ex=1) or squashed (cond_ex=0). With en=0 nothing changes.
module cond_logic_unit #(
    parameter int REG_OUTPUTS = 0,
    parameter int CNT_W       = 16,
    parameter int NV_EXECUTES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    input  logic             cnt_clr,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0]       flags_q;
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] squash_q;
    logic             n_f, z_f, c_f, v_f;
    logic             exec_now;
    logic             squash_now;
    logic             pc_src_c, reg_write_c, mem_write_c;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Condition evaluation always uses the registered flags (no ALU bypass).
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = (NV_EXECUTES != 0);
            default: cond_ex = 1'b0;
        endcase
    end

    assign exec_now    = en & cond_ex;
    assign squash_now  = en & ~cond_ex;
    assign pc_src_c    = exec_now & pcs;
    assign reg_write_c = exec_now & reg_w & ~no_write;
    assign mem_write_c = exec_now & mem_w;

    generate
        if (REG_OUTPUTS != 0) begin : g_reg_strobes
            // Registered strobes: one cycle of latency, cleared by reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pc_src    <= 1'b0;
                    reg_write <= 1'b0;
                    mem_write <= 1'b0;
                end else begin
                    pc_src    <= pc_src_c;
                    reg_write <= reg_write_c;
                    mem_write <= mem_write_c;
                end
            end
        end else begin : g_comb_strobes
            assign pc_src    = pc_src_c;
            assign reg_write = reg_write_c;
            assign mem_write = mem_write_c;
        end
    endgenerate

    // Flag register: N,Z and C,V groups update independently, only when executed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (exec_now && flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
            if (exec_now && flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
        end
    end

    // Performance counters: saturating, clear takes priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (cnt_clr) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            if (exec_now && (exec_q != {CNT_W{1'b1}}))     exec_q   <= exec_q + 1'b1;
            if (squash_now && (squash_q != {CNT_W{1'b1}})) squash_q <= squash_q + 1'b1;
        end
    end

    assign flags      = flags_q;
    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;

endmodule

// File: tb/tb_cond_logic_unit.sv
// Bench for cond_logic_unit: two instances driven in lockstep, one with
// combinational strobes / 16-bit counters / NV never, one with registered
// strobes / 2-bit counters / NV as AL. Directed table, hand sequences for
// latency, saturation, clear priority and async reset, then random traffic,
// all checked against a behavioural model.
module tb_cond_logic_unit;

  typedef struct {
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs, rw, mw, nw, clr;
    logic       x_ce, x_pc, x_rw, x_mw;
    logic [3:0] x_fl;
  } vec_t;

  logic clk, reset;
  logic en, pcs, reg_w, mem_w, no_write, cnt_clr;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_w;

  logic pc_src0, reg_write0, mem_write0, cond_ex0;
  logic [3:0] flags0;
  logic [15:0] exec_cnt0, squash_cnt0;
  logic pc_src1, reg_write1, mem_write1, cond_ex1;
  logic [3:0] flags1;
  logic [1:0] exec_cnt1, squash_cnt1;

  int checks = 0;
  int errors = 0;

  // behavioural model state, index 0 = dut0, 1 = dut1
  logic [3:0] m_flags [2];
  int         m_exec  [2];
  int         m_sq    [2];
  int         m_max   [2];
  logic [2:0] m_strb1;           // dut1 registered {pc, reg, mem}

  cond_logic_unit #(.REG_OUTPUTS(0), .CNT_W(16), .NV_EXECUTES(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .cond(cond), .alu_flags(alu_flags),
    .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
    .cnt_clr(cnt_clr), .pc_src(pc_src0), .reg_write(reg_write0), .mem_write(mem_write0),
    .cond_ex(cond_ex0), .flags(flags0), .exec_cnt(exec_cnt0), .squash_cnt(squash_cnt0)
  );

  cond_logic_unit #(.REG_OUTPUTS(1), .CNT_W(2), .NV_EXECUTES(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .cond(cond), .alu_flags(alu_flags),
    .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
    .cnt_clr(cnt_clr), .pc_src(pc_src1), .reg_write(reg_write1), .mem_write(mem_write1),
    .cond_ex(cond_ex1), .flags(flags1), .exec_cnt(exec_cnt1), .squash_cnt(squash_cnt1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs: even code = base test, odd = its inverse.
  function automatic logic cond_pass(input logic [3:0] f, input logic [3:0] c, input bit nv);
    bit n, z, cy, v;
    bit base [8];
    bit r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    base = '{z, cy, n, v, cy && !z, n == v, !z && (n == v), 1'b1};
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return nv;
    r = base[c[3:1]];
    return c[0] ? !r : r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_flags[i] = 4'b0000;
      m_exec[i]  = 0;
      m_sq[i]    = 0;
    end
    m_strb1 = 3'b000;
  endtask

  // next-state of the model for the inputs currently applied
  task automatic model_step();
    logic ce;
    for (int i = 0; i < 2; i++) begin
      ce = cond_pass(m_flags[i], cond, i == 1);
      if (i == 1) m_strb1 = {en && ce && pcs, en && ce && reg_w && !no_write, en && ce && mem_w};
      if (cnt_clr) begin
        m_exec[i] = 0;
        m_sq[i]   = 0;
      end else if (en) begin
        if (ce) m_exec[i] = (m_exec[i] < m_max[i]) ? m_exec[i] + 1 : m_max[i];
        else    m_sq[i]   = (m_sq[i]   < m_max[i]) ? m_sq[i] + 1   : m_max[i];
      end
      if (en && ce && flag_w[1]) m_flags[i][3:2] = alu_flags[3:2];
      if (en && ce && flag_w[0]) m_flags[i][1:0] = alu_flags[1:0];
    end
  endtask

  task automatic check_all();
    logic ce0, ce1;
    ce0 = cond_pass(m_flags[0], cond, 1'b0);
    ce1 = cond_pass(m_flags[1], cond, 1'b1);
    chk("d0_cond_ex",   32'(cond_ex0),    32'(ce0));
    chk("d0_pc_src",    32'(pc_src0),     32'(en && ce0 && pcs));
    chk("d0_reg_write", 32'(reg_write0),  32'(en && ce0 && reg_w && !no_write));
    chk("d0_mem_write", 32'(mem_write0),  32'(en && ce0 && mem_w));
    chk("d0_flags",     32'(flags0),      32'(m_flags[0]));
    chk("d0_exec_cnt",  32'(exec_cnt0),   32'(m_exec[0]));
    chk("d0_squash",    32'(squash_cnt0), 32'(m_sq[0]));
    chk("d1_cond_ex",   32'(cond_ex1),    32'(ce1));
    chk("d1_strobes",   32'({pc_src1, reg_write1, mem_write1}), 32'(m_strb1));
    chk("d1_flags",     32'(flags1),      32'(m_flags[1]));
    chk("d1_exec_cnt",  32'(exec_cnt1),   32'(m_exec[1]));
    chk("d1_squash",    32'(squash_cnt1), 32'(m_sq[1]));
  endtask

  // driver
  task automatic drive(input vec_t v);
    en = v.en; cond = v.cond; alu_flags = v.alu; flag_w = v.fw;
    pcs = v.pcs; reg_w = v.rw; mem_w = v.mw; no_write = v.nw; cnt_clr = v.clr;
  endtask

  // one instruction slot: inputs already at posedge+1, check at negedge
  task automatic run_cycle(input vec_t v, input bit hand, input string tag);
    drive(v);
    @(negedge clk);
    check_all();
    if (hand) begin
      chk({tag, "_ce"},    32'(cond_ex0),   32'(v.x_ce));
      chk({tag, "_pc"},    32'(pc_src0),    32'(v.x_pc));
      chk({tag, "_rw"},    32'(reg_write0), 32'(v.x_rw));
      chk({tag, "_mw"},    32'(mem_write0), 32'(v.x_mw));
      chk({tag, "_flags"}, 32'(flags0),     32'(v.x_fl));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic e, input logic [3:0] c, input logic [3:0] a,
                              input logic [1:0] fw, input logic p, input logic rw,
                              input logic mw, input logic nw, input logic clr,
                              input logic xce, input logic xpc, input logic xrw,
                              input logic xmw, input logic [3:0] xfl);
    vec_t v;
    v.en = e; v.cond = c; v.alu = a; v.fw = fw; v.pcs = p; v.rw = rw; v.mw = mw;
    v.nw = nw; v.clr = clr; v.x_ce = xce; v.x_pc = xpc; v.x_rw = xrw; v.x_mw = xmw;
    v.x_fl = xfl;
    return v;
  endfunction

  vec_t tbl [16];
  vec_t v;

  initial begin
    // table: inputs | expected dut0 outputs in that cycle
    tbl[0]  = mk(1, 4'h0, 4'b0000, 2'b00, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4'b0000); // EQ fails after reset
    tbl[1]  = mk(1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000); // AL sets Z
    tbl[2]  = mk(1, 4'h0, 4'b0000, 2'b00, 0, 1, 0, 0, 0,  1, 0, 1, 0, 4'b0100); // EQ now passes
    tbl[3]  = mk(1, 4'h1, 4'b0000, 2'b11, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4'b0100); // NE squashed
    tbl[4]  = mk(1, 4'hE, 4'b0000, 2'b00, 0, 1, 0, 1, 0,  1, 0, 0, 0, 4'b0100); // flags kept, CMP
    tbl[5]  = mk(1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100); // clear flags
    tbl[6]  = mk(1, 4'hE, 4'b1111, 2'b10, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000); // NZ only
    tbl[7]  = mk(1, 4'hA, 4'b0000, 2'b00, 1, 1, 1, 0, 0,  0, 0, 0, 0, 4'b1100); // GE fails
    tbl[8]  = mk(1, 4'hB, 4'b0000, 2'b00, 0, 0, 1, 0, 0,  1, 0, 0, 1, 4'b1100); // LT store
    tbl[9]  = mk(1, 4'hD, 4'b0000, 2'b00, 1, 0, 0, 0, 0,  1, 1, 0, 0, 4'b1100); // LE branch
    tbl[10] = mk(1, 4'hC, 4'b0000, 2'b00, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4'b1100); // GT fails
    tbl[11] = mk(0, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0, 0,  1, 0, 0, 0, 4'b1100); // bubble
    tbl[12] = mk(1, 4'hF, 4'b0000, 2'b00, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4'b1100); // NV never
    tbl[13] = mk(1, 4'h9, 4'b0000, 2'b00, 0, 1, 0, 0, 0,  1, 0, 1, 0, 4'b1100); // LS via Z
    tbl[14] = mk(1, 4'hE, 4'b0011, 2'b01, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1100); // CV only
    tbl[15] = mk(1, 4'h8, 4'b0000, 2'b00, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4'b1111); // HI fails

    m_max[0] = 65535;
    m_max[1] = 3;
    reset = 1'b1;
    drive(mk(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_flags0", 32'(flags0), 32'h0);
    chk("rst_exec0",  32'(exec_cnt0), 32'h0);
    chk("rst_sq1",    32'(squash_cnt1), 32'h0);
    chk("rst_strb1",  32'({pc_src1, reg_write1, mem_write1}), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));
    chk("tbl_squash0", 32'(squash_cnt0), 32'd6);
    chk("tbl_exec0",   32'(exec_cnt0),   32'd9);

    // saturation of the 2-bit counter, then clear beats increment
    run_cycle(mk(0, 4'hE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "");
    for (int i = 0; i < 5; i++) run_cycle(mk(1, 4'hE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "");
    chk("sat_exec1", 32'(exec_cnt1), 32'd3);
    chk("sat_exec0", 32'(exec_cnt0), 32'd5);
    run_cycle(mk(1, 4'hE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "");
    chk("clr_exec1", 32'(exec_cnt1), 32'd0);
    chk("clr_exec0", 32'(exec_cnt0), 32'd0);

    // registered pc_src: high exactly one cycle after the en cycle
    drive(mk(1, 4'hE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("lat_pc1_c0", 32'(pc_src1), 32'd0);
    chk("lat_pc0_c0", 32'(pc_src0), 32'd1);
    model_step();
    @(posedge clk); #1;
    drive(mk(0, 4'hE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("lat_pc1_c1", 32'(pc_src1), 32'd1);
    chk("lat_pc0_c1", 32'(pc_src0), 32'd0);
    model_step();
    @(posedge clk); #1;
    run_cycle(mk(0, 4'hE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "");
    chk("lat_pc1_c2", 32'(pc_src1), 32'd0);

    // asynchronous reset in the middle of an executing instruction
    run_cycle(mk(1, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, "");
    drive(mk(1, 4'hE, 4'b0101, 2'b11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("pre_rst_flags0", 32'(flags0), 32'b1010);
    chk("pre_rst_pc1",    32'(pc_src1), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_flags0", 32'(flags0), 32'h0);
    chk("arst_flags1", 32'(flags1), 32'h0);
    chk("arst_exec0",  32'(exec_cnt0), 32'h0);
    chk("arst_strb1",  32'({pc_src1, reg_write1, mem_write1}), 32'h0);
    model_reset();
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_flags0", 32'(flags0), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             $urandom_range(0, 31) == 0, 0, 0, 0, 0, 0);
      run_cycle(v, 1'b0, "");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
